// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Pipeline hazard controller sitting beside the ID/EX stages. It tracks
// outstanding register writes with one down-counter per architectural
// register, so write-back latency may be any number of cycles. It also
// produces a multi-cycle ID flush after a taken branch and drains all
// outstanding writes before signalling IRQ entry.
//
// Parameters:
//   N_SRC     - number of source-operand ports checked in ID (>= 1)
//   WB_LAT    - cycles after EX issue before a written register is readable (>= 1)
//   FLUSH_CYC - cycles o_id_flush is held after a taken branch (>= 1)
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_src_code  source register codes, port k at [4k+3:4k]
//   i_src_vld   per-port source valid
//   i_wr_issue  EX instruction writes a register this cycle
//   i_wr_code   destination register of that write
//   i_pc_en     taken branch / PC write from EX
//   i_irq_flag  interrupt request from EX
//   o_id_flush  flush ID
//   o_ex_flush  flush EX (insert NOP)
//   o_bubble    hold PC and IF/ID
//   o_irq_take  one-cycle pulse: enter IRQ vector now
//   o_pending   bit r set while register r has a write outstanding
module hazard_scoreboard #(
  parameter int N_SRC     = 3,
  parameter int WB_LAT    = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [4*N_SRC-1:0] i_src_code,
  input  logic [N_SRC-1:0]   i_src_vld,
  input  logic               i_wr_issue,
  input  logic [3:0]         i_wr_code,
  input  logic               i_pc_en,
  input  logic               i_irq_flag,
  output logic               o_id_flush,
  output logic               o_ex_flush,
  output logic               o_bubble,
  output logic               o_irq_take,
  output logic [15:0]        o_pending
);

  localparam int PW = $clog2(WB_LAT + 1);
  // Sized from FLUSH_CYC+1 so the counter is at least one bit wide even
  // when FLUSH_CYC is 1 (the counter then never leaves zero).
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_TAKE
  } state_t;

  logic [15:0]      pend_vec;
  logic [N_SRC-1:0] port_hit;
  logic             hazard_data;
  logic             hazard_wb_b;
  logic             all_clear;
  logic [FW-1:0]    fcnt_reg;
  state_t           state_reg;
  state_t           state_next;

  // ---------------------------------------------------------------------
  // Per-register pending-write counters. An issue always reloads the
  // counter, which also covers a re-issue to a register still pending.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pend
      logic [PW-1:0] cnt_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_reg <= '0;
        end else if (i_wr_issue && (i_wr_code == 4'(gi))) begin
          cnt_reg <= PW'(WB_LAT);
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      assign pend_vec[gi] = (cnt_reg != '0);
    end
  endgenerate

  assign o_pending = pend_vec;
  assign all_clear = (pend_vec == 16'h0000);

  // ---------------------------------------------------------------------
  // Source-operand hazard check. The EX-stage issue is compared directly
  // because its counter only becomes visible from the next cycle.
  // ---------------------------------------------------------------------
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_port
      logic [3:0] src_code;
      assign src_code     = i_src_code[4*gi +: 4];
      assign port_hit[gi] = i_src_vld[gi] &
                            (pend_vec[src_code] | (i_wr_issue & (src_code == i_wr_code)));
    end
  endgenerate

  assign hazard_data = |port_hit;
  // A write to r15 is a PC write-back: the instruction behind it is squashed.
  assign hazard_wb_b = i_wr_issue & (i_wr_code == 4'hF);

  // ---------------------------------------------------------------------
  // Branch flush counter: the pc_en cycle itself is covered combinationally,
  // the counter covers the remaining FLUSH_CYC-1 cycles.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcnt_reg <= '0;
    end else if (i_pc_en) begin
      fcnt_reg <= FW'(FLUSH_CYC - 1);
    end else if (fcnt_reg != '0) begin
      fcnt_reg <= fcnt_reg - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // IRQ drain FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        // An issue this cycle will load a counter, so it cannot go straight to TAKE.
        if (i_irq_flag) begin
          state_next = (all_clear && !i_wr_issue) ? ST_TAKE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (all_clear) begin
          state_next = ST_TAKE;
        end
      end
      ST_TAKE: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_id_flush = i_pc_en | (fcnt_reg != '0);
  assign o_bubble   = hazard_data | (state_reg == ST_DRAIN);
  assign o_ex_flush = i_pc_en | (fcnt_reg != '0) | hazard_wb_b | hazard_data |
                      i_irq_flag | (state_reg != ST_RUN);
  assign o_irq_take = (state_reg == ST_TAKE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard (N_SRC=3, WB_LAT=2, FLUSH_CYC=3).
// Each scenario task holds a table of per-cycle stimulus rows with the
// expected output word {bubble, id_flush, ex_flush, irq_take, pending[15:0]}.
// Expectations are queued as a row is driven and popped when the outputs
// are sampled on the falling edge of that cycle.
module tb_hazard_scoreboard;

  localparam int N_SRC     = 3;
  localparam int WB_LAT    = 2;
  localparam int FLUSH_CYC = 3;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic [4*N_SRC-1:0] i_src_code = '0;
  logic [N_SRC-1:0]   i_src_vld = '0;
  logic               i_wr_issue = 1'b0;
  logic [3:0]         i_wr_code = '0;
  logic               i_pc_en = 1'b0;
  logic               i_irq_flag = 1'b0;
  logic               o_id_flush;
  logic               o_ex_flush;
  logic               o_bubble;
  logic               o_irq_take;
  logic [15:0]        o_pending;

  hazard_scoreboard #(
    .N_SRC    (N_SRC),
    .WB_LAT   (WB_LAT),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_src_code(i_src_code),
    .i_src_vld (i_src_vld),
    .i_wr_issue(i_wr_issue),
    .i_wr_code (i_wr_code),
    .i_pc_en   (i_pc_en),
    .i_irq_flag(i_irq_flag),
    .o_id_flush(o_id_flush),
    .o_ex_flush(o_ex_flush),
    .o_bubble  (o_bubble),
    .o_irq_take(o_irq_take),
    .o_pending (o_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] src_code;
    logic [2:0]  src_vld;
    logic        wr_issue;
    logic [3:0]  wr_code;
    logic        pc_en;
    logic        irq;
    logic [19:0] exp;
  } row_t;

  typedef struct {
    string       tag;
    int          cyc;
    logic [19:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Expected output word: {bubble, id_flush, ex_flush, irq_take, pending}
  function automatic logic [19:0] ew(input logic b, input logic idf, input logic exf,
                                     input logic tk, input logic [15:0] p);
    return {b, idf, exf, tk, p};
  endfunction

  function automatic row_t mk(input logic [11:0] sc, input logic [2:0] sv, input logic wi,
                              input logic [3:0] wc, input logic pc, input logic irq,
                              input logic [19:0] e);
    row_t r;
    r.src_code = sc; r.src_vld = sv; r.wr_issue = wi; r.wr_code = wc;
    r.pc_en = pc; r.irq = irq; r.exp = e;
    return r;
  endfunction

  task automatic drive(input row_t r);
    i_src_code = r.src_code;
    i_src_vld  = r.src_vld;
    i_wr_issue = r.wr_issue;
    i_wr_code  = r.wr_code;
    i_pc_en    = r.pc_en;
    i_irq_flag = r.irq;
  endtask

  function automatic logic [19:0] obs_word();
    return {o_bubble, o_id_flush, o_ex_flush, o_irq_take, o_pending};
  endfunction

  task automatic test_reset();
    exp_t e;
    logic [19:0] obs;
    i_rst_n = 1'b0;
    drive(mk(12'h000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 20'h0));
    exp_q.push_back('{"reset", 0, ew(0, 0, 0, 0, 16'h0000)});
    @(negedge i_clk);
    obs = obs_word();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e.val) begin
      miscompares++;
      $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
    end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // issue r3 at c0, port0 reads r3 throughout
    rows.push_back(mk(12'h003, 3'b001, 1, 4'h3, 0, 0, ew(1, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h003, 3'b001, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0008)));
    rows.push_back(mk(12'h003, 3'b001, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0008)));
    rows.push_back(mk(12'h003, 3'b001, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"back_to_back", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reissue();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // r5 issued at c0 and c1, port1 reads r5
    rows.push_back(mk(12'h050, 3'b010, 1, 4'h5, 0, 0, ew(1, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h050, 3'b010, 1, 4'h5, 0, 0, ew(1, 0, 1, 0, 16'h0020)));
    rows.push_back(mk(12'h050, 3'b010, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0020)));
    rows.push_back(mk(12'h050, 3'b010, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0020)));
    rows.push_back(mk(12'h050, 3'b010, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"reissue", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_branch_flush();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // single branch: flush c0..c2
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 1, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    // branch at c4, re-branch at c5: flush through c7
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 1, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 1, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    // branch and IRQ together, empty scoreboard: take pulse next cycle
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 1, 1, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 1, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 1, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"branch_flush", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_pc_wb();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // r15 issue with every port pointing at r15 but invalid
    rows.push_back(mk(12'hFFF, 3'b000, 1, 4'hF, 0, 0, ew(0, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'hFFF, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h8000)));
    // valid port on an unrelated register: still no bubble
    rows.push_back(mk(12'h7FF, 3'b100, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h8000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    // port2 reading r9 while r9 is issued
    rows.push_back(mk(12'h900, 3'b100, 1, 4'h9, 0, 0, ew(1, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0200)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0200)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"pc_wb", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_irq_drain();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // r1 at c0, IRQ at c1: DRAIN c2..c3, TAKE c4
    rows.push_back(mk(12'h000, 3'b000, 1, 4'h1, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 1, ew(0, 0, 1, 0, 16'h0002)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0002)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 1, 1, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    // IRQ with empty scoreboard: take next cycle
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 1, ew(0, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 1, 1, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    // IRQ with a same-cycle issue drains; a reissue during DRAIN extends it,
    // and IRQ held high during DRAIN is ignored
    rows.push_back(mk(12'h000, 3'b000, 1, 4'h2, 0, 1, ew(0, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 1, 4'h2, 0, 1, ew(1, 0, 1, 0, 16'h0004)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 1, ew(1, 0, 1, 0, 16'h0004)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0004)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 1, 1, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"irq_drain", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    row_t rows[$];
    exp_t e;
    logic [19:0] obs;
    // r4 at c0, IRQ at c1 -> DRAIN with r4 still pending in c2
    rows.push_back(mk(12'h000, 3'b000, 1, 4'h4, 0, 0, ew(0, 0, 0, 0, 16'h0000)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 1, ew(0, 0, 1, 0, 16'h0010)));
    rows.push_back(mk(12'h000, 3'b000, 0, 4'h0, 0, 0, ew(1, 0, 1, 0, 16'h0010)));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back('{"mid_drain", i, rows[i].exp});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      if (i < rows.size() - 1) begin
        @(posedge i_clk); #1;
      end
    end
    // Still in DRAIN, between edges: assert reset, effect must be immediate.
    #1;
    i_rst_n = 1'b0;
    #1;
    exp_q.push_back('{"rst_async", 0, ew(0, 0, 0, 0, 16'h0000)});
    obs = obs_word();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e.val) begin
      miscompares++;
      $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
    end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    // after release: no stale bubble, flush or take pulse
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{"post_rst", i, ew(0, 0, 0, 0, 16'h0000)});
      @(negedge i_clk);
      obs = obs_word();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.val) begin
        miscompares++;
        $display("FAIL %s c%0d got=%05h want=%05h", e.tag, e.cyc, obs, e.val);
      end else $display("ok   %s c%0d out=%05h", e.tag, e.cyc, obs);
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reissue();
    test_branch_flush();
    test_pc_wb();
    test_irq_drain();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the ARMv4 core. It replaces single-stage EX-to-ID dependency checking with a per-register pending-write scoreboard, so write-back latency can be any number of cycles. It also adds a parametrised multi-cycle branch flush and an interrupt drain sequence that holds the pipeline until all outstanding writes have retired. It sits beside the ID/EX stages and drives their flush and bubble controls.

## Interface
Parameters:
- `N_SRC`, default 3: number of source-register operand ports checked in ID (Rm, Rn, Rs); minimum 1.
- `WB_LAT`, default 2: cycles after EX issue before a written register is readable from the register file; minimum 1.
- `FLUSH_CYC`, default 1: cycles `o_id_flush` is held after a taken branch; minimum 1.

Ports:
- `i_clk`, in, 1: clock. One clock domain.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_src_code`, in, 4*N_SRC: source register codes; port k occupies bits [4k+3:4k].
- `i_src_vld`, in, N_SRC: per-port valid.
- `i_wr_issue`, in, 1: the instruction in EX writes a register this cycle. Already qualified by condition-pass upstream.
- `i_wr_code`, in, 4: destination register of that write.
- `i_pc_en`, in, 1: taken branch / PC write from EX.
- `i_irq_flag`, in, 1: interrupt request from EX.
- `o_id_flush`, out, 1: flush ID.
- `o_ex_flush`, out, 1: flush EX (insert NOP).
- `o_bubble`, out, 1: hold PC and IF/ID.
- `o_irq_take`, out, 1: one-cycle pulse; the core enters IRQ vector now.
- `o_pending`, out, 16: bit r set while register r has a write outstanding.

## Operation
**Scoreboard**
- Sixteen counters `pend[r]`, width `$clog2(WB_LAT+1)`, all 0 at reset.
- Per cycle, if `i_wr_issue` and `r == i_wr_code`, `pend[r] <= WB_LAT`.
- Otherwise, if `pend[r] != 0`, `pend[r] <= pend[r] - 1`.
- A re-issue to an already pending register reloads its counter to `WB_LAT`.
- `o_pending[r] = (pend[r] != 0)`.

**Hazards (combinational)**
- `hazard_data`: any port k has `i_src_vld[k]` and either `pend[src_k] != 0`, or (`i_wr_issue` and `src_k == i_wr_code`).
- `hazard_wb_b`: `i_wr_issue` and `i_wr_code == 4'hF`.
- `fcnt`: branch flush counter, 0 at reset.
  - On `i_pc_en`, `fcnt <= FLUSH_CYC-1`.
  - Otherwise, if `fcnt != 0`, it decrements.
- `o_id_flush = i_pc_en | (fcnt != 0)`.

**IRQ FSM**: states RUN (reset), DRAIN, TAKE.
- RUN → TAKE when `i_irq_flag`, all `pend == 0`, and `!i_wr_issue`.
- RUN → DRAIN when `i_irq_flag` otherwise.
- DRAIN → TAKE when all `pend == 0`. Stay in DRAIN otherwise.
- TAKE → RUN unconditionally.
- `i_irq_flag` is ignored in DRAIN and TAKE.
- Issues arriving during DRAIN still load the scoreboard and extend the drain.

**Outputs**
- `o_bubble = hazard_data | (state == DRAIN)`.
- `o_ex_flush = i_pc_en | (fcnt != 0) | hazard_wb_b | hazard_data | i_irq_flag | (state != RUN)`.
- `o_irq_take = (state == TAKE)`.

## Timing
- Reset: all counters, `fcnt` and state are cleared asynchronously. Outputs at reset:
  - `o_pending = 0`, `o_irq_take = 0`.
  - `o_bubble`, `o_id_flush` and `o_ex_flush` are 0 when all inputs are 0.
- Reset asserted mid-drain or mid-flush: the state returns to RUN immediately and no `o_irq_take` is emitted.
- Data hazard latency: a write issued in cycle t stalls dependent sources in cycles t..t+WB_LAT and releases them in t+WB_LAT+1.
  - Example, `WB_LAT = 2`: stall in t, t+1, t+2; clear in t+3.
- Branch in cycle t:
  - `o_id_flush` and `o_ex_flush` are high for cycles t..t+FLUSH_CYC-1.
  - A new `i_pc_en` inside that window restarts the count.
- IRQ in cycle t with an empty scoreboard: `o_irq_take` is high in t+1.
- IRQ with writes pending: `o_irq_take` is high in the cycle after the last counter reaches 0.
- Simultaneous `i_pc_en` and `i_irq_flag`: both take effect; the flush and the IRQ FSM proceed independently.
- An issue and a decrement on the same register in the same cycle: the issue wins.

## Test plan
- **Back-to-back dependency.** `WB_LAT=2`. Issue r3 at cycle 10; ID reads r3 (port 0) continuously. Required: `o_bubble=1` for cycles 10–12 and 0 at cycle 13; `o_pending[3]=1` for cycles 11–12.
- **Reissue.** Issue r5 at cycle 0 and again at cycle 1. Required: `pend[5]` reads 2, 2, 1, 0 in cycles 1–4; a reader of r5 stalls through cycle 3.
- **Multi-cycle branch flush.** `FLUSH_CYC=3`, `i_pc_en` at cycle 4. Required: `o_id_flush=1` in cycles 4–6 and 0 at cycle 7. A second `i_pc_en` at cycle 5 extends the flush through cycle 7.
- **PC write-back and invalid ports.** Issue r15. Required: `o_ex_flush=1` that cycle and `o_bubble=0`. With `i_src_vld=0` on all ports, no bubble is produced.
- **IRQ drain.** Issue r1 at cycle 0 and `i_irq_flag` at cycle 1 (`WB_LAT=2`). Required: DRAIN in cycles 2–3 with `o_bubble=1` and `o_ex_flush=1`; `o_irq_take=1` only in cycle 4. Asserting `i_irq_flag` with an empty scoreboard gives the take pulse on the next cycle.
- **Reset mid-drain.** Deassert `i_rst_n` during DRAIN. Required: `o_pending=0` and `o_irq_take=0` immediately; after release, no stale bubble or take pulse.
